// File: rtl/clint_bus_slave.sv
// Core-local interruptor (msip, mtime, mtimecmp) answering the crossbar's clint port.
// Optional rtc_tick prescaler enabled by defining CLINT_PRESCALE_EN.
module clint_bus_slave #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned PRESCALE  = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        clint_mstReq_valid,
  output logic        clint_mstReq_ready,
  input  logic [63:0] clint_addr,
  input  logic [63:0] clint_data_w,
  input  logic [7:0]  clint_wstrb,
  input  logic        clint_wen,
  output logic [63:0] clint_data_r,
  output logic        clint_slvRsp_valid,
  input  logic        rtc_tick,
  output logic        isRTimerInterrupt,
  output logic        isSoftwvInterrupt
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RSP  = 1'b1
  } state_e;

  localparam logic [12:0] IDX_MSIP     = 13'h0000;
  localparam logic [12:0] IDX_MTIMECMP = 13'h0800;
  localparam logic [12:0] IDX_MTIME    = 13'h17FF;

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    res = old_v;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) begin
        res[i*8 +: 8] = new_v[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = old_v[i*8 +: 8];
      end
    end
    return res;
  endfunction

  state_e      state_q;
  logic        ready_q, rsp_q, mtip_q, msip_irq_q, msip_q, msip_d;
  logic [63:0] data_r_q, mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;

  logic [63:0] offset_s, rdata_s, mtime_inc_s;
  logic [12:0] idx_s;
  logic        in_range_s, accept_s, wr_s, wr_mtime_s, tick_en_s;

  // Address decode relative to the region base; below-base addresses wrap to a huge offset.
  always_comb begin
    offset_s   = clint_addr - BASE_ADDR;
    in_range_s = (offset_s[63:16] == 48'd0);
    idx_s      = offset_s[15:3];
    accept_s   = clint_mstReq_valid && (state_q == ST_IDLE);
    wr_s       = accept_s && clint_wen && in_range_s;
    wr_mtime_s = wr_s && (idx_s == IDX_MTIME);
  end

`ifdef CLINT_PRESCALE_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pcnt_q;

  assign tick_en_s = rtc_tick && (pcnt_q == PW'(PRESCALE - 1));

  // Prescale counter; a bus write to mtime restarts the divide period.
  always_ff @(posedge CLK) begin
    if (RST || wr_mtime_s) begin
      pcnt_q <= '0;
    end else if (rtc_tick) begin
      pcnt_q <= tick_en_s ? '0 : pcnt_q + 1'b1;
    end else begin
      pcnt_q <= pcnt_q;
    end
  end
`else
  assign tick_en_s = rtc_tick;
`endif

  // Read mux, sampled at the acceptance edge so mtime is the pre-increment value.
  always_comb begin
    rdata_s = 64'd0;
    if (in_range_s) begin
      case (idx_s)
        IDX_MSIP:     rdata_s = {63'd0, msip_q};
        IDX_MTIMECMP: rdata_s = mtimecmp_q;
        IDX_MTIME:    rdata_s = mtime_q;
        default:      rdata_s = 64'd0;
      endcase
    end else begin
      rdata_s = 64'd0;
    end
  end

  // Register next-state: written mtime lanes override the incremented value.
  always_comb begin
    mtime_inc_s = mtime_q + {63'd0, tick_en_s};
    msip_d      = msip_q;
    mtimecmp_d  = mtimecmp_q;
    mtime_d     = mtime_inc_s;
    if (wr_s) begin
      case (idx_s)
        IDX_MSIP:     msip_d = clint_wstrb[0] ? clint_data_w[0] : msip_q;
        IDX_MTIMECMP: mtimecmp_d = merge_bytes(mtimecmp_q, clint_data_w, clint_wstrb);
        IDX_MTIME:    mtime_d = merge_bytes(mtime_inc_s, clint_data_w, clint_wstrb);
        default:      msip_d = msip_q;
      endcase
    end else begin
      msip_d = msip_q;
    end
  end

  // Handshake FSM, register file and registered interrupt lines.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b1;
      rsp_q      <= 1'b0;
      data_r_q   <= 64'd0;
      msip_q     <= 1'b0;
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      mtip_q     <= 1'b0;
      msip_irq_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_q  <= ST_RSP;
            ready_q  <= 1'b0;
            rsp_q    <= 1'b1;
            data_r_q <= clint_wen ? 64'd0 : rdata_s;
          end else begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            rsp_q    <= 1'b0;
          end
        end
        ST_RSP: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          rsp_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          rsp_q   <= 1'b0;
        end
      endcase
      msip_q     <= msip_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      mtip_q     <= (mtime_q >= mtimecmp_q);
      msip_irq_q <= msip_q;
    end
  end

  assign clint_mstReq_ready = ready_q;
  assign clint_slvRsp_valid = rsp_q;
  assign clint_data_r       = data_r_q;
  assign isRTimerInterrupt  = mtip_q;
  assign isSoftwvInterrupt  = msip_irq_q;

endmodule

// File: tb/tb_clint_bus_slave.sv
// Directed self-checking bench for clint_bus_slave (handshake, timer, msip, decode, reset).
module tb_clint_bus_slave;
  localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
`ifdef CLINT_PRESCALE_EN
  localparam int TDIV = 4;
`else
  localparam int TDIV = 1;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        clint_mstReq_valid = 1'b0;
  logic        clint_mstReq_ready;
  logic [63:0] clint_addr = 64'd0;
  logic [63:0] clint_data_w = 64'd0;
  logic [7:0]  clint_wstrb = 8'd0;
  logic        clint_wen = 1'b0;
  logic [63:0] clint_data_r;
  logic        clint_slvRsp_valid;
  logic        rtc_tick = 1'b0;
  logic        isRTimerInterrupt;
  logic        isSoftwvInterrupt;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  clint_bus_slave #(.BASE_ADDR(BASE), .PRESCALE(4)) dut (
    .CLK(CLK), .RST(RST),
    .clint_mstReq_valid(clint_mstReq_valid), .clint_mstReq_ready(clint_mstReq_ready),
    .clint_addr(clint_addr), .clint_data_w(clint_data_w), .clint_wstrb(clint_wstrb),
    .clint_wen(clint_wen), .clint_data_r(clint_data_r), .clint_slvRsp_valid(clint_slvRsp_valid),
    .rtc_tick(rtc_tick), .isRTimerInterrupt(isRTimerInterrupt), .isSoftwvInterrupt(isSoftwvInterrupt)
  );

  // One access issued from IDLE; returns the response flag and data seen in the RSP cycle.
  task automatic bus(input logic wen, input logic [63:0] addr, input logic [63:0] wd,
                     input logic [7:0] strb, input logic tk,
                     output logic [63:0] rd, output logic rsp);
    clint_mstReq_valid = 1'b1; clint_wen = wen; clint_addr = addr;
    clint_data_w = wd; clint_wstrb = strb; rtc_tick = tk;
    @(posedge CLK); #1;
    clint_mstReq_valid = 1'b0; clint_wen = 1'b0; rtc_tick = 1'b0;
    rsp = clint_slvRsp_valid; rd = clint_data_r;
    @(posedge CLK); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      rtc_tick = 1'b1; @(posedge CLK); #1;
      rtc_tick = 1'b0; @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    if (clint_mstReq_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", clint_mstReq_ready); end
    checks++;
    if (clint_slvRsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp: got %b expected 0", clint_slvRsp_valid); end
    checks++;
    if (clint_data_r !== 64'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", clint_data_r); end
    checks++;
    if ({isRTimerInterrupt, isSoftwvInterrupt} !== 2'b00) begin errors++; $display("FAIL reset_irq: got %b expected 00", {isRTimerInterrupt, isSoftwvInterrupt}); end
    checks++;
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_read_latency();
    clint_mstReq_valid = 1'b1; clint_wen = 1'b0; clint_addr = BASE + 64'hBFF8;
    clint_data_w = 64'hDEAD_BEEF_DEAD_BEEF; clint_wstrb = 8'hFF;
    if (clint_slvRsp_valid !== 1'b0) begin errors++; $display("FAIL lat_pre_rsp: got %b expected 0", clint_slvRsp_valid); end
    checks++;
    @(posedge CLK); #1;
    clint_mstReq_valid = 1'b0;
    if (clint_slvRsp_valid !== 1'b1) begin errors++; $display("FAIL lat_rsp: got %b expected 1", clint_slvRsp_valid); end
    checks++;
    if (clint_mstReq_ready !== 1'b0) begin errors++; $display("FAIL lat_ready_low: got %b expected 0", clint_mstReq_ready); end
    checks++;
    if (clint_data_r !== 64'd0) begin errors++; $display("FAIL lat_data: got %h expected 0", clint_data_r); end
    checks++;
    @(posedge CLK); #1;
    if (clint_slvRsp_valid !== 1'b0) begin errors++; $display("FAIL lat_rsp_drop: got %b expected 0", clint_slvRsp_valid); end
    checks++;
    if (clint_mstReq_ready !== 1'b1) begin errors++; $display("FAIL lat_ready_high: got %b expected 1", clint_mstReq_ready); end
    checks++;
  endtask

  task automatic test_timer_irq();
    logic [63:0] rd; logic rsp;
    bus(1'b1, BASE + 64'h4000, 64'd5, 8'hFF, 1'b0, rd, rsp);
    ticks(5 * TDIV - 1);
    if (isRTimerInterrupt !== 1'b0) begin errors++; $display("FAIL tmr_before: got %b expected 0", isRTimerInterrupt); end
    checks++;
    rtc_tick = 1'b1; @(posedge CLK); #1; rtc_tick = 1'b0;
    if (isRTimerInterrupt !== 1'b0) begin errors++; $display("FAIL tmr_same_cycle: got %b expected 0", isRTimerInterrupt); end
    checks++;
    @(posedge CLK); #1;
    if (isRTimerInterrupt !== 1'b1) begin errors++; $display("FAIL tmr_rise: got %b expected 1", isRTimerInterrupt); end
    checks++;
    bus(1'b0, BASE + 64'hBFF8, 64'd0, 8'h00, 1'b0, rd, rsp);
    if (rd !== 64'd5) begin errors++; $display("FAIL tmr_mtime5: got %h expected 5", rd); end
    checks++;
    bus(1'b1, BASE + 64'h4000, 64'd100, 8'hFF, 1'b0, rd, rsp);
    if (isRTimerInterrupt !== 1'b0) begin errors++; $display("FAIL tmr_fall: got %b expected 0", isRTimerInterrupt); end
    checks++;
    bus(1'b1, BASE + 64'h4000, 64'hAAAA_BBBB_1122_3344, 8'h03, 1'b0, rd, rsp);
    bus(1'b0, BASE + 64'h4000, 64'd0, 8'h00, 1'b0, rd, rsp);
    if (rd !== 64'h0000_0000_0000_3344) begin errors++; $display("FAIL cmp_partial: got %h expected 3344", rd); end
    checks++;
  endtask

  task automatic test_msip();
    logic [63:0] rd; logic rsp;
    bus(1'b1, BASE, 64'd1, 8'h00, 1'b0, rd, rsp);
    if (isSoftwvInterrupt !== 1'b0) begin errors++; $display("FAIL msip_nostrb_irq: got %b expected 0", isSoftwvInterrupt); end
    checks++;
    bus(1'b0, BASE, 64'd0, 8'h00, 1'b0, rd, rsp);
    if (rd !== 64'd0) begin errors++; $display("FAIL msip_nostrb_rd: got %h expected 0", rd); end
    checks++;
    bus(1'b1, BASE + 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01, 1'b0, rd, rsp);
    if (isSoftwvInterrupt !== 1'b1) begin errors++; $display("FAIL msip_set_irq: got %b expected 1", isSoftwvInterrupt); end
    checks++;
    bus(1'b0, BASE, 64'd0, 8'h00, 1'b0, rd, rsp);
    if (rd !== 64'd1) begin errors++; $display("FAIL msip_set_rd: got %h expected 1", rd); end
    checks++;
    bus(1'b1, BASE, 64'd0, 8'h01, 1'b0, rd, rsp);
    if (isSoftwvInterrupt !== 1'b0) begin errors++; $display("FAIL msip_clr_irq: got %b expected 0", isSoftwvInterrupt); end
    checks++;
  endtask

  task automatic test_mtime_wrap();
    logic [63:0] rd; logic rsp;
    bus(1'b1, BASE + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 1'b0, rd, rsp);
    ticks(2 * TDIV);
    bus(1'b0, BASE + 64'hBFF8, 64'd0, 8'h00, 1'b0, rd, rsp);
    if (rd !== 64'd0) begin errors++; $display("FAIL mtime_wrap: got %h expected 0", rd); end
    checks++;
    bus(1'b1, BASE + 64'hBFF8, 64'h10, 8'hFF, 1'b1, rd, rsp);
    bus(1'b0, BASE + 64'hBFF8, 64'd0, 8'h00, 1'b0, rd, rsp);
    if (rd !== 64'h10) begin errors++; $display("FAIL mtime_wr_tick: got %h expected 10", rd); end
    checks++;
    bus(1'b0, BASE + 64'hBFF8, 64'd0, 8'h00, 1'b1, rd, rsp);
    if (rd !== 64'h10) begin errors++; $display("FAIL mtime_rd_pre: got %h expected 10", rd); end
    checks++;
    bus(1'b0, BASE + 64'hBFF8, 64'd0, 8'h00, 1'b0, rd, rsp);
    if (rd !== ((TDIV == 1) ? 64'h11 : 64'h10)) begin errors++; $display("FAIL mtime_rd_post: got %h expected %h", rd, (TDIV == 1) ? 64'h11 : 64'h10); end
    checks++;
    bus(1'b1, BASE + 64'hBFF8, 64'hFF, 8'hFF, 1'b0, rd, rsp);
    bus(1'b1, BASE + 64'hBFF8, 64'h55, 8'h01, 1'b1, rd, rsp);
    bus(1'b0, BASE + 64'hBFF8, 64'd0, 8'h00, 1'b0, rd, rsp);
    if (rd !== ((TDIV == 1) ? 64'h155 : 64'h055)) begin errors++; $display("FAIL mtime_partial_tick: got %h expected %h", rd, (TDIV == 1) ? 64'h155 : 64'h055); end
    checks++;
  endtask

  task automatic test_unmapped();
    logic [63:0] rd; logic rsp;
    bus(1'b1, BASE, 64'd1, 8'h01, 1'b0, rd, rsp);
    bus(1'b1, BASE + 64'hBFF8, 64'h1234, 8'hFF, 1'b0, rd, rsp);
    bus(1'b0, BASE + 64'h1000, 64'd0, 8'h00, 1'b0, rd, rsp);
    if (rsp !== 1'b1 || rd !== 64'd0) begin errors++; $display("FAIL unmap_rd: got rsp %b data %h expected rsp 1 data 0", rsp, rd); end
    checks++;
    bus(1'b1, BASE + 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, rd, rsp);
    if (rsp !== 1'b1) begin errors++; $display("FAIL unmap_wr_rsp: got %b expected 1", rsp); end
    checks++;
    bus(1'b1, BASE + 64'h1_4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, rd, rsp);
    bus(1'b1, BASE - 64'h8, 64'd0, 8'hFF, 1'b0, rd, rsp);
    bus(1'b0, BASE + 64'h1_BFF8, 64'd0, 8'h00, 1'b0, rd, rsp);
    if (rsp !== 1'b1 || rd !== 64'd0) begin errors++; $display("FAIL oor_rd: got rsp %b data %h expected rsp 1 data 0", rsp, rd); end
    checks++;
    bus(1'b0, BASE, 64'd0, 8'h00, 1'b0, rd, rsp);
    if (rd !== 64'd1) begin errors++; $display("FAIL unmap_msip: got %h expected 1", rd); end
    checks++;
    bus(1'b0, BASE + 64'h4000, 64'd0, 8'h00, 1'b0, rd, rsp);
    if (rd !== 64'h3344) begin errors++; $display("FAIL unmap_mtimecmp: got %h expected 3344", rd); end
    checks++;
    bus(1'b0, BASE + 64'hBFF8, 64'd0, 8'h00, 1'b0, rd, rsp);
    if (rd !== 64'h1234) begin errors++; $display("FAIL unmap_mtime: got %h expected 1234", rd); end
    checks++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd; logic rsp;
    clint_mstReq_valid = 1'b1; clint_wen = 1'b0; clint_addr = BASE + 64'h4000;
    @(posedge CLK); #1;
    clint_mstReq_valid = 1'b0;
    RST = 1'b1;
    @(posedge CLK); #1;
    if (clint_slvRsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rsp: got %b expected 0", clint_slvRsp_valid); end
    checks++;
    if (clint_mstReq_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", clint_mstReq_ready); end
    checks++;
    RST = 1'b0;
    @(posedge CLK); #1;
    if (isSoftwvInterrupt !== 1'b0) begin errors++; $display("FAIL rstmid_swi: got %b expected 0", isSoftwvInterrupt); end
    checks++;
    bus(1'b0, BASE + 64'h4000, 64'd0, 8'h00, 1'b0, rd, rsp);
    if (rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL rstmid_mtimecmp: got %h expected all ones", rd); end
    checks++;
    bus(1'b0, BASE + 64'hBFF8, 64'd0, 8'h00, 1'b0, rd, rsp);
    if (rd !== 64'd0) begin errors++; $display("FAIL rstmid_mtime: got %h expected 0", rd); end
    checks++;
  endtask

`ifdef CLINT_PRESCALE_EN
  task automatic test_prescale();
    logic [63:0] rd; logic rsp;
    bus(1'b1, BASE + 64'hBFF8, 64'd0, 8'hFF, 1'b0, rd, rsp);
    ticks(7);
    bus(1'b0, BASE + 64'hBFF8, 64'd0, 8'h00, 1'b0, rd, rsp);
    if (rd !== 64'd1) begin errors++; $display("FAIL prescale_7: got %h expected 1", rd); end
    checks++;
    ticks(1);
    bus(1'b0, BASE + 64'hBFF8, 64'd0, 8'h00, 1'b0, rd, rsp);
    if (rd !== 64'd2) begin errors++; $display("FAIL prescale_8: got %h expected 2", rd); end
    checks++;
  endtask
`endif

  initial begin
    test_reset();
    test_read_latency();
    test_timer_irq();
    test_msip();
    test_mtime_wrap();
    test_unmapped();
    test_reset_mid();
`ifdef CLINT_PRESCALE_EN
    test_prescale();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
